// File: rtl/mux_8x1_rr_sched_if.sv
// Request/select/grant bundle between the requesters and the
// round-robin mux scheduler. LOCK exists only with MUX_SCHED_LOCK_EN.
interface mux_8x1_rr_sched_if;
  logic [7:0] REQ;
  logic       S0;
  logic       S1;
  logic       S2;
  logic [7:0] GNT;
  logic       BUSY;
  logic       SWITCH;
`ifdef MUX_SCHED_LOCK_EN
  logic       LOCK;
`endif

  modport master (
    output REQ,
`ifdef MUX_SCHED_LOCK_EN
    output LOCK,
`endif
    input  S0, S1, S2, GNT, BUSY, SWITCH
  );

  modport slave (
    input  REQ,
`ifdef MUX_SCHED_LOCK_EN
    input  LOCK,
`endif
    output S0, S1, S2, GNT, BUSY, SWITCH
  );
endinterface

// File: rtl/mux_8x1_rr_sched.sv
// Round-robin burst-limited scheduler driving an 8:1 mux select.
// Optional MUX_SCHED_LOCK_EN adds LOCK to suppress the burst limit.
module mux_8x1_rr_sched #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input logic               CLK,
  input logic               RST_N,
  mux_8x1_rr_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [2:0]       ptr;
  logic [2:0]       sel;
  logic [2:0]       last_idx;
  logic             last_vld;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       gnt;
  logic             busy;
  logic             sw;

  logic [2:0]       pick;
  logic             hit;
  logic             lock;
  logic             rel;

`ifdef MUX_SCHED_LOCK_EN
  assign lock = bus.LOCK;
`else
  assign lock = 1'b0;
`endif

  // Walk downward so the smallest offset from ptr wins.
  always_comb begin
    pick = ptr;
    hit  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.REQ[ptr + 3'(k)]) begin
        pick = ptr + 3'(k);
        hit  = 1'b1;
      end
    end
  end

  assign rel = !bus.REQ[sel] ||
               ((cnt == CNT_MAX) && !lock);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      last_idx <= 3'd0;
      last_vld <= 1'b0;
      cnt      <= '0;
      gnt      <= 8'h00;
      busy     <= 1'b0;
      sw       <= 1'b0;
    end else begin
      sw <= 1'b0;
      case (state)
        ST_IDLE, ST_GAP: begin
          if (hit) begin
            state    <= ST_GRANT;
            gnt      <= 8'b1 << pick;
            sel      <= pick;
            busy     <= 1'b1;
            cnt      <= CNT_ONE;
            sw       <= !last_vld || (pick != last_idx);
            last_idx <= pick;
            last_vld <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            state <= ST_GAP;
            gnt   <= 8'h00;
            busy  <= 1'b0;
            ptr   <= sel + 3'd1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.S0     = sel[0];
  assign bus.S1     = sel[1];
  assign bus.S2     = sel[2];
  assign bus.GNT    = gnt;
  assign bus.BUSY   = busy;
  assign bus.SWITCH = sw;

endmodule
